// File: rtl/wb_queue.sv
// Writeback stage: decodes a retiring RV32I instruction, aligns load data and
// queues register-file writes in a DEPTH-entry FIFO. Define WB_FWD_EN to add forwarding ports.
module wb_queue #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  instr_i,
  input  logic [31:0]                  alu_result_i,
  input  logic [31:0]                  data_i,
  output logic                         rf_we_o,
  output logic [4:0]                   rf_rd_o,
  output logic [31:0]                  rf_wdata_o,
  input  logic                         rf_ready_i,
  output logic                         misalign_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
`ifdef WB_FWD_EN
  ,
  input  logic [4:0]                   fwd_rs1_i,
  input  logic [4:0]                   fwd_rs2_i,
  output logic                         fwd_hit1_o,
  output logic                         fwd_hit2_o,
  output logic [31:0]                  fwd_data1_o,
  output logic [31:0]                  fwd_data2_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        is_load;
  logic        is_alu;
  logic        load_ok;
  logic        load_mis;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        accept;
  logic        push;
  logic        pop;

  logic [4:0]    ent_rd_q   [DEPTH];
  logic [4:0]    ent_rd_d   [DEPTH];
  logic [31:0]   ent_data_q [DEPTH];
  logic [31:0]   ent_data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          misalign_q, misalign_d;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[31:15];

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd     = instr_i[11:7];

  assign byte_sel = data_i[{alu_result_i[1:0], 3'b000} +: 8];
  assign half_sel = alu_result_i[1] ? data_i[31:16] : data_i[15:0];

  always_comb begin
    is_load   = (opcode == OPC_LOAD);
    is_alu    = (opcode == OPC_OP) || (opcode == OPC_OP_IMM) || (opcode == OPC_LUI) ||
                (opcode == OPC_AUIPC) || (opcode == OPC_JAL) || (opcode == OPC_JALR);
    load_ok   = 1'b0;
    load_mis  = 1'b0;
    load_data = '0;
    case (funct3)
      3'b000: begin
        load_ok   = 1'b1;
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      3'b001: begin
        load_mis  = alu_result_i[0];
        load_ok   = ~alu_result_i[0];
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      3'b010: begin
        load_mis  = (alu_result_i[1:0] != 2'b00);
        load_ok   = (alu_result_i[1:0] == 2'b00);
        load_data = data_i;
      end
      3'b100: begin
        load_ok   = 1'b1;
        load_data = {24'h0, byte_sel};
      end
      3'b101: begin
        load_mis  = alu_result_i[0];
        load_ok   = ~alu_result_i[0];
        load_data = {16'h0, half_sel};
      end
      default: begin
        load_ok   = 1'b0;
        load_mis  = 1'b0;
      end
    endcase
    wr_en   = is_load ? load_ok : is_alu;
    wr_data = is_load ? load_data : alu_result_i;
  end

  assign in_ready_o = (count_q != CW'(DEPTH));
  assign accept     = in_valid_i && in_ready_o;
  // x0 writes and non-writers are consumed without taking a slot
  assign push       = accept && wr_en && (rd != 5'd0);
  assign pop        = (count_q != '0) && rf_ready_i;

  always_comb begin
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = accept && is_load && load_mis;
    if (push) begin
      ent_rd_d[wr_ptr_q]   = rd;
      ent_data_d[wr_ptr_q] = wr_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_rd_q   <= '{default: '0};
      ent_data_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign count_o    = count_q;
  assign misalign_o = misalign_q;
  assign rf_we_o    = (count_q != '0);
  assign rf_rd_o    = rf_we_o ? ent_rd_q[rd_ptr_q]   : 5'd0;
  assign rf_wdata_o = rf_we_o ? ent_data_q[rd_ptr_q] : 32'd0;

`ifdef WB_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Walk oldest to newest so the newest matching entry overwrites older hits
  always_comb begin
    fwd_idx     = '0;
    fwd_hit1_o  = 1'b0;
    fwd_hit2_o  = 1'b0;
    fwd_data1_o = '0;
    fwd_data2_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((fwd_rs1_i != 5'd0) && (ent_rd_q[fwd_idx] == fwd_rs1_i)) begin
          fwd_hit1_o  = 1'b1;
          fwd_data1_o = ent_data_q[fwd_idx];
        end
        if ((fwd_rs2_i != 5'd0) && (ent_rd_q[fwd_idx] == fwd_rs2_i)) begin
          fwd_hit2_o  = 1'b1;
          fwd_data2_o = ent_data_q[fwd_idx];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue (DEPTH=2): decode/alignment vector table plus
// hand-written backpressure, same-edge push/pop, async reset and forwarding sequences.
module tb_wb_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] alu_result_i;
  logic [31:0] data_i;
  logic        rf_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_wdata_o;
  logic        rf_ready_i;
  logic        misalign_o;
  logic [1:0]  count_o;
`ifdef WB_FWD_EN
  logic [4:0]  fwd_rs1_i, fwd_rs2_i;
  logic        fwd_hit1_o, fwd_hit2_o;
  logic [31:0] fwd_data1_o, fwd_data2_o;
`endif

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .instr_i      (instr_i),
    .alu_result_i (alu_result_i),
    .data_i       (data_i),
    .rf_we_o      (rf_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_wdata_o   (rf_wdata_o),
    .rf_ready_i   (rf_ready_i),
    .misalign_o   (misalign_o),
    .count_o      (count_o)
`ifdef WB_FWD_EN
    ,
    .fwd_rs1_i    (fwd_rs1_i),
    .fwd_rs2_i    (fwd_rs2_i),
    .fwd_hit1_o   (fwd_hit1_o),
    .fwd_hit2_o   (fwd_hit2_o),
    .fwd_data1_o  (fwd_data1_o),
    .fwd_data2_o  (fwd_data2_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int wlog[$];

  always @(posedge clk)
    if (rst_n && rf_we_o && rf_ready_i) wlog.push_back(int'(rf_rd_o));

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] data;
    logic        push;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] dat);
    in_valid_i   = 1'b1;
    instr_i      = ins;
    alu_result_i = alu;
    data_i       = dat;
  endtask

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] OP = 7'b0110011;
  localparam logic [6:0] OI = 7'b0010011;

  initial begin
    vecs[0]  = '{mk(LD, 3'b000, 5'd5),  32'h2,        32'h1280_3456, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{mk(LD, 3'b100, 5'd5),  32'h2,        32'h1280_3456, 1'b1, 5'd5,  32'h0000_0080, 1'b0};
    vecs[2]  = '{mk(LD, 3'b001, 5'd6),  32'h1,        32'h1280_3456, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[3]  = '{mk(LD, 3'b010, 5'd7),  32'h0,        32'hDEAD_BEEF, 1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{mk(OP, 3'b000, 5'd3),  32'h42,       32'h0,         1'b1, 5'd3,  32'h0000_0042, 1'b0};
    vecs[5]  = '{mk(7'b0100011, 3'b010, 5'd3), 32'h42, 32'h0,        1'b0, 5'd0,  32'h0,         1'b0};
    vecs[6]  = '{mk(OI, 3'b000, 5'd0),  32'h42,       32'h0,         1'b0, 5'd0,  32'h0,         1'b0};
    vecs[7]  = '{mk(LD, 3'b101, 5'd9),  32'h2,        32'h1280_3456, 1'b1, 5'd9,  32'h0000_1280, 1'b0};
    vecs[8]  = '{mk(LD, 3'b001, 5'd10), 32'h0,        32'h0000_8001, 1'b1, 5'd10, 32'hFFFF_8001, 1'b0};
    vecs[9]  = '{mk(LD, 3'b010, 5'd11), 32'h2,        32'h1111_2222, 1'b0, 5'd0,  32'h0,         1'b1};
    vecs[10] = '{mk(LD, 3'b011, 5'd12), 32'h0,        32'h1111_2222, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[11] = '{mk(7'b0110111, 3'b000, 5'd1), 32'h1234_5000, 32'h0, 1'b1, 5'd1,  32'h1234_5000, 1'b0};
    vecs[12] = '{mk(7'b1100011, 3'b000, 5'd8), 32'h8,  32'h0,        1'b0, 5'd0,  32'h0,         1'b0};
    vecs[13] = '{mk(LD, 3'b000, 5'd2),  32'h3,        32'h7F00_0000, 1'b1, 5'd2,  32'h0000_007F, 1'b0};

    rst_n = 1'b0; in_valid_i = 1'b0; instr_i = '0; alu_result_i = '0; data_i = '0; rf_ready_i = 1'b0;
`ifdef WB_FWD_EN
    fwd_rs1_i = '0; fwd_rs2_i = '0;
`endif
    #12;
    check("reset count", 32'(count_o), 32'd0);
    check("reset we", 32'(rf_we_o), 32'd0);
    check("reset rd", 32'(rf_rd_o), 32'd0);
    check("reset wdata", rf_wdata_o, 32'd0);
    check("reset misalign", 32'(misalign_o), 32'd0);
    check("reset ready", 32'(in_ready_o), 32'd1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      offer(vecs[i].instr, vecs[i].alu, vecs[i].data);
      rf_ready_i = 1'b0;
      step();
      in_valid_i = 1'b0;
      check($sformatf("v%0d count", i), 32'(count_o), 32'(vecs[i].push));
      check($sformatf("v%0d we", i), 32'(rf_we_o), 32'(vecs[i].push));
      check($sformatf("v%0d rd", i), 32'(rf_rd_o), 32'(vecs[i].rd));
      check($sformatf("v%0d wdata", i), rf_wdata_o, vecs[i].wdata);
      check($sformatf("v%0d misalign", i), 32'(misalign_o), 32'(vecs[i].mis));
      rf_ready_i = 1'b1;
      step();
      rf_ready_i = 1'b0;
      check($sformatf("v%0d drained", i), 32'(count_o), 32'd0);
      check($sformatf("v%0d misalign one-shot", i), 32'(misalign_o), 32'd0);
    end

    // Backpressure with DEPTH=2: fill, stall, then drain while accepting the rest
    wlog.delete();
    offer(mk(OP, 3'b000, 5'd11), 32'd101, 32'h0);
    step();
    check("bp count1", 32'(count_o), 32'd1);
    offer(mk(OP, 3'b000, 5'd12), 32'd102, 32'h0);
    step();
    check("bp count2", 32'(count_o), 32'd2);
    check("bp ready low", 32'(in_ready_o), 32'd0);
    offer(mk(OP, 3'b000, 5'd13), 32'd103, 32'h0);
    step();
    check("bp hold count", 32'(count_o), 32'd2);
    check("bp hold head", 32'(rf_rd_o), 32'd11);
    check("bp hold wdata", rf_wdata_o, 32'd101);
    rf_ready_i = 1'b1;
    step();
    check("bp pop1 count", 32'(count_o), 32'd1);
    check("bp pop1 head", 32'(rf_rd_o), 32'd12);
    check("bp ready back", 32'(in_ready_o), 32'd1);
    step();
    check("bp pushpop count", 32'(count_o), 32'd1);
    check("bp pushpop head", 32'(rf_rd_o), 32'd13);
    check("bp pushpop wdata", rf_wdata_o, 32'd103);
    offer(mk(OP, 3'b000, 5'd14), 32'd104, 32'h0);
    step();
    check("bp last count", 32'(count_o), 32'd1);
    check("bp last head", 32'(rf_rd_o), 32'd14);
    // Discarded store plus a pop on the same edge
    offer(mk(7'b0100011, 3'b010, 5'd0), 32'h0, 32'h0);
    step();
    in_valid_i = 1'b0;
    rf_ready_i = 1'b0;
    check("discard+pop count", 32'(count_o), 32'd0);
    check("drain log size", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < wlog.size()) check($sformatf("drain order %0d", i), 32'(wlog[i]), 32'(11 + i));

    // Asynchronous reset with two entries queued
    offer(mk(OP, 3'b000, 5'd20), 32'd1, 32'h0);
    step();
    offer(mk(OP, 3'b000, 5'd21), 32'd2, 32'h0);
    step();
    in_valid_i = 1'b0;
    check("pre-reset count", 32'(count_o), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async count", 32'(count_o), 32'd0);
    check("async we", 32'(rf_we_o), 32'd0);
    check("async rd", 32'(rf_rd_o), 32'd0);
    check("async wdata", rf_wdata_o, 32'd0);
    check("async ready", 32'(in_ready_o), 32'd1);
    #3;
    rst_n = 1'b1;
    step();
    check("post-reset count", 32'(count_o), 32'd0);

`ifdef WB_FWD_EN
    offer(mk(OI, 3'b000, 5'd4), 32'd1, 32'h0);
    step();
    offer(mk(OI, 3'b000, 5'd4), 32'd2, 32'h0);
    step();
    in_valid_i = 1'b0;
    fwd_rs1_i = 5'd4;
    fwd_rs2_i = 5'd0;
    #1;
    check("fwd hit1", 32'(fwd_hit1_o), 32'd1);
    check("fwd data1 newest", fwd_data1_o, 32'd2);
    check("fwd hit2 x0", 32'(fwd_hit2_o), 32'd0);
    fwd_rs2_i = 5'd9;
    #1;
    check("fwd hit2 miss", 32'(fwd_hit2_o), 32'd0);
    rf_ready_i = 1'b1;
    step();
    step();
    rf_ready_i = 1'b0;
    check("fwd empty hit1", 32'(fwd_hit1_o), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Parametrised writeback stage with an input valid/ready handshake and a DEPTH-entry result queue in front of the register-file write port. It decodes the retiring RV32I instruction, sign/zero-extends and lane-aligns load data, selects the ALU result for non-load writers, and drops x0 writes. It flags misaligned loads. Because the shared register-file write port can refuse a write, the queue lets the pipeline keep retiring while the port is busy. It sits between the memory stage and the register file.

## Interface
- DEPTH, 2, queue entries; power of two, at least 2
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  memory stage offers an instruction
- in_ready_o  out  1  stage accepts; equals (count_o != DEPTH), no combinational path from rf_ready_i
- instr_i  in  32  retiring instruction
- alu_result_i  in  32  ALU result; bits [1:0] are the load byte offset
- data_i  in  32  word read from data memory
- rf_we_o  out  1  head entry valid; equals (count_o != 0)
- rf_rd_o  out  5  head destination register; 0 when empty
- rf_wdata_o  out  32  head write data; 0 when empty
- rf_ready_i  in  1  register file accepts the write this cycle
- misalign_o  out  1  one-cycle pulse: the misaligned load accepted last cycle
- count_o  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Accept when in_valid_i && in_ready_o. Decode on opcode instr_i[6:0], funct3 instr_i[14:12], rd instr_i[11:7].
- LOAD (0000011):
  - LB/LBU select byte alu_result_i[1:0].
  - LH/LHU select halfword alu_result_i[1]; require alu_result_i[0]=0.
  - LW requires alu_result_i[1:0]=0.
  - LB/LH sign-extend from the selected lane's MSB; LBU/LHU zero-extend.
  - Undefined funct3 (011, 110, 111): no write, no flag.
- OP, OP-IMM, LUI, AUIPC, JAL, JALR: write alu_result_i.
- All other opcodes (branch, store, fence, system, illegal): no write.
- No write means accepted and discarded; no queue entry is created.
- rd == 0: accepted, discarded, no entry.
- Misaligned load: discarded, no entry. misalign_o asserts the following cycle for exactly one cycle.
- Pop when rf_we_o && rf_ready_i. Queue order is strict FIFO. Pointers wrap modulo DEPTH.

## Timing
- Reset: count_o=0, rf_we_o=0, rf_rd_o=0, rf_wdata_o=0, misalign_o=0, in_ready_o=1, pointers 0. Entry contents are don't-care.
- Reset mid-operation discards all queued entries immediately.
- Latency: accepted at edge N, the entry is visible at the head after edge N if the queue was empty.
- Sustained throughput is 1 per cycle with rf_ready_i held high.
- Push and pop on the same edge: count unchanged, both occur.
  - Legal only when the queue is not full, because in_ready_o=0 when full.
  - A discarded instruction plus a pop decrements count.
- Full: in_ready_o=0; upstream holds instr_i and operands stable until accepted.
- Empty: a push becomes visible next cycle; no same-cycle bypass to rf_* outputs.
- rf_ready_i with an empty queue has no effect.

## Configuration
- WB_FWD_EN defined adds these ports:
  - fwd_rs1_i, fwd_rs2_i: in, 5 each.
  - fwd_hit1_o, fwd_hit2_o: out, 1 each.
  - fwd_data1_o, fwd_data2_o: out, 32 each.
- Forwarding behaviour:
  - Combinational search of valid queue entries; the newest entry with matching rd wins.
  - rs == 0 never hits.
  - No search of the input port; hit is 0 when there is no match.
- WB_FWD_EN undefined: these ports and the search logic are absent. Upstream must stall on any pending rd, using count_o != 0 as a conservative hazard.

## Test plan
- LB x5, offset 2, data_i=32'h12_80_34_56 -> entry rd=5, wdata=32'hFFFF_FF80. LBU, same inputs -> 32'h0000_0080.
- LH offset 1 -> no entry, misalign_o=1 for one cycle. LW offset 0, data 32'hDEAD_BEEF, rd=7 -> wdata 32'hDEAD_BEEF.
- ADD x3 with alu_result 32'h0000_0042, then a store, then ADDI x0:
  - Exactly one entry (rd=3, wdata=0x42).
  - All three accepted.
- DEPTH=2, rf_ready_i=0, four valid writers offered back-to-back:
  - in_ready_o drops after 2 accepts.
  - Then rf_ready_i=1 -> writes drain in order, one per cycle.
  - Remaining two accepted.
- Push and pop on the same edge with count=1 -> count stays 1. Assert rst_n low with count=2 -> all outputs 0 asynchronously.
- WB_FWD_EN: entries x4=1 then x4=2 queued, fwd_rs1_i=4 -> hit1=1, data1=2. fwd_rs2_i=0 -> hit2=0.
